// File: rtl/decode_issue_queue_if.sv
// Handshake bundle between decode, the issue queue and the issue stage.
// slave = the queue itself; master = the surrounding decode/issue/execute logic.
interface decode_issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 flush_i;
    logic [PAYLOAD_W-1:0] in_instr_i;
    logic                 in_is_ctrl_flow_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [PAYLOAD_W-1:0] issue_instr_o;
    logic                 issue_is_ctrl_flow_o;
    logic                 issue_valid_o;
    logic                 issue_ack_i;
    logic                 resolve_branch_i;
    logic                 branch_pending_o;
    logic [CNT_W-1:0]     count_o;

    modport slave (
        input  flush_i, in_instr_i, in_is_ctrl_flow_i, in_valid_i,
        input  issue_ack_i, resolve_branch_i,
        output in_ready_o, issue_instr_o, issue_is_ctrl_flow_o, issue_valid_o,
        output branch_pending_o, count_o
    );

    modport master (
        output flush_i, in_instr_i, in_is_ctrl_flow_i, in_valid_i,
        output issue_ack_i, resolve_branch_i,
        input  in_ready_o, issue_instr_o, issue_is_ctrl_flow_o, issue_valid_o,
        input  branch_pending_o, count_o
    );
endinterface

// File: rtl/decode_issue_queue.sv
// Decode-to-issue FIFO that stalls issue behind an unresolved control-flow instruction.
// Optional feature: define ISSUE_QUEUE_BYPASS_EN for a 0-cycle empty-queue bypass.
module decode_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input logic                  clk_i,
    input logic                  rst_i,
    decode_issue_queue_if.slave  q
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PAYLOAD_W-1:0] payload [DEPTH];
    logic                 ctrl    [DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 pending;

    logic in_ready, head_valid, bypass, take_bypass, push, pop, popped_ctrl;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        in_ready   = (count < FULL_CNT);
        head_valid = (count != '0) && !pending;
`ifdef ISSUE_QUEUE_BYPASS_EN
        bypass     = (count == '0) && !pending && q.in_valid_i && !q.flush_i;
`else
        bypass     = 1'b0;
`endif
        take_bypass = bypass && q.issue_ack_i;
        push        = q.in_valid_i && in_ready && !q.flush_i && !take_bypass;
        pop         = q.issue_ack_i && head_valid && !q.flush_i;
        popped_ctrl = (pop && ctrl[rd_ptr]) || (take_bypass && q.in_is_ctrl_flow_i);
    end

    assign q.in_ready_o       = in_ready;
    assign q.count_o          = count;
    assign q.branch_pending_o = pending;
    assign q.issue_valid_o    = head_valid || bypass;
`ifdef ISSUE_QUEUE_BYPASS_EN
    assign q.issue_instr_o        = bypass ? q.in_instr_i : payload[rd_ptr];
    assign q.issue_is_ctrl_flow_o = bypass ? q.in_is_ctrl_flow_i : ctrl[rd_ptr];
`else
    assign q.issue_instr_o        = payload[rd_ptr];
    assign q.issue_is_ctrl_flow_o = ctrl[rd_ptr];
`endif

    // Payload storage carries no reset; only the control state below is cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            payload[wr_ptr] <= q.in_instr_i;
            ctrl[wr_ptr]    <= q.in_is_ctrl_flow_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || q.flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A newly issued branch outranks a same-cycle resolve of the old one.
            if (popped_ctrl)            pending <= 1'b1;
            else if (q.resolve_branch_i) pending <= 1'b0;
        end
    end
endmodule
